// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, addressing-mode constants, instruction
// field positions and the fetch-stage state type.
package cpu_pkg;

    localparam logic [3:0] NOOP = 4'd0;
    localparam logic [3:0] LOD  = 4'd1;
    localparam logic [3:0] STR  = 4'd2;
    localparam logic [3:0] SWAP = 4'd3;
    localparam logic [3:0] BRA  = 4'd4;
    localparam logic [3:0] BRR  = 4'd5;
    localparam logic [3:0] BNE  = 4'd6;
    localparam logic [3:0] ALU  = 4'd8;
    localparam logic [3:0] HLT  = 4'd15;

    localparam logic [3:0] AM_IMM = 4'd8;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int MM_HI  = 27;
    localparam int MM_LO  = 24;
    localparam int OFF_HI = 15;
    localparam int OFF_LO = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's control inputs from ctrl, the instruction
// memory handshake and the fetch results presented back to ctrl.
interface fetch_unit_if #(
    parameter int ADDR_W = 16
) ();
    logic              PC_RST;
    logic              PC_WRITE;
    logic              PC_SEL;
    logic              BR_SEL;
    logic              IMEM_REQ;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic              IMEM_RDY;
    logic [31:0]       IMEM_DATA;
    logic [31:0]       INSTR;
    logic [3:0]        OPCODE;
    logic [3:0]        MM;
    logic              INSTR_VALID;
    logic              STALL;
    logic [ADDR_W-1:0] PC;

    // The fetch unit itself
    modport master (
        input  PC_RST, PC_WRITE, PC_SEL, BR_SEL, IMEM_RDY, IMEM_DATA,
        output IMEM_REQ, IMEM_ADDR, INSTR, OPCODE, MM, INSTR_VALID, STALL, PC
    );

    // Everything around it: ctrl plus instruction memory
    modport slave (
        output PC_RST, PC_WRITE, PC_SEL, BR_SEL, IMEM_RDY, IMEM_DATA,
        input  IMEM_REQ, IMEM_ADDR, INSTR, OPCODE, MM, INSTR_VALID, STALL, PC
    );
endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// Combinational next-PC logic: increment, relative and absolute branch
// targets, and the selected next PC (redirect beats increment beats hold).
module pc_next_calc #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic [15:0]       offset,
    input  logic [ADDR_W-1:0] abs_field,
    input  logic              br_sel,
    input  logic              redirect,
    input  logic              inc,
    output logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] next_pc
);
    logic signed [15:0] offset_s;
    logic [ADDR_W-1:0]  offset_ext;

    assign offset_s   = offset;
    assign offset_ext = ADDR_W'(offset_s);

    // Target selection and next-PC mux; all sums wrap modulo 2^ADDR_W
    always_comb begin
        target  = br_sel ? abs_field : instr_pc + offset_ext;
        next_pc = pc;
        if (redirect) begin
            next_pc = target;
        end else if (inc) begin
            next_pc = pc + ADDR_W'(1);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and the instruction register, issues one
// memory read per PC_WRITE rising edge and applies ctrl's branch commands.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic        CLK,
    input  logic        RST,
    fetch_unit_if.master bus
);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, instr_pc_q, addr_q, pend_tgt_q;
    logic [31:0]       instr_q;
    logic              valid_q, req_q, pend_q, pw_prev_q;
    logic              pw_edge, start, done, redirect;
    logic [ADDR_W-1:0] target, next_pc;

    assign pw_edge  = bus.PC_WRITE && !pw_prev_q;
    assign redirect = bus.PC_SEL && (state_q == ST_IDLE);

    pc_next_calc #(.ADDR_W(ADDR_W)) u_calc (
        .pc        (pc_q),
        .instr_pc  (instr_pc_q),
        .offset    (instr_q[OFF_HI:OFF_LO]),
        .abs_field (instr_q[ADDR_W-1:0]),
        .br_sel    (bus.BR_SEL),
        .redirect  (redirect),
        .inc       (done),
        .target    (target),
        .next_pc   (next_pc)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state plus fetch start/completion strobes; PC_RST overrides all
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done    = 1'b0;
        if (!bus.PC_RST) begin
            case (state_q)
                ST_IDLE: if (pw_edge) begin
                    state_d = ST_REQ;
                    start   = 1'b1;
                end
                ST_REQ: if (bus.IMEM_RDY) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = ST_IDLE;
        end
    end

    // PC, instruction register, memory request and pending-redirect state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q       <= RST_PC;
            instr_pc_q <= RST_PC;
            addr_q     <= RST_PC;
            pend_tgt_q <= RST_PC;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            pend_q     <= 1'b0;
            pw_prev_q  <= 1'b0;
        end else begin
            pw_prev_q <= bus.PC_WRITE;
            if (bus.PC_RST) begin
                pc_q    <= RST_PC;
                valid_q <= 1'b0;
                req_q   <= 1'b0;
                pend_q  <= 1'b0;
            end else if (done) begin
                req_q <= 1'b0;
                if (pend_q) begin
                    pc_q   <= pend_tgt_q;
                    pend_q <= 1'b0;
                end else begin
                    instr_q <= bus.IMEM_DATA;
                    valid_q <= 1'b1;
                    pc_q    <= next_pc;
                end
            end else if (state_q == ST_REQ) begin
                // Redirect during an outstanding fetch waits for completion
                if (bus.PC_SEL) begin
                    pend_q     <= 1'b1;
                    pend_tgt_q <= target;
                end
            end else begin
                // Redirect first, so a same-cycle fetch uses the new target
                pc_q <= next_pc;
                if (start) begin
                    addr_q     <= next_pc;
                    instr_pc_q <= next_pc;
                    req_q      <= 1'b1;
                    valid_q    <= 1'b0;
                end
            end
        end
    end

    assign bus.IMEM_REQ    = req_q;
    assign bus.IMEM_ADDR   = addr_q;
    assign bus.INSTR       = instr_q;
    assign bus.OPCODE      = instr_q[OPC_HI:OPC_LO];
    assign bus.MM          = instr_q[MM_HI:MM_LO];
    assign bus.INSTR_VALID = valid_q;
    assign bus.STALL       = (state_q == ST_REQ);
    assign bus.PC          = pc_q;
endmodule
